// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter driving the select lines of a shared 4:1 mux datapath
//   clk, rst (async, active-high) | req[3:0] per-requester request
//   gnt[3:0] one-hot registered grant | s1:s0 owner index | busy = |gnt | timeout one-cycle preempt pulse
module mux4_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, owner, owner_n, sel, sel_n, win;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
  logic [3:0] gnt_n, rot;
  logic timeout_n, release_now, expire;
  // rot[i] is the request at priority rank i, counted from ptr
  assign rot = 4'({req, req} >> ptr);
  assign win = ptr + (rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3);
  assign release_now = !req[owner];
  assign expire = (HOLD_MAX != 0) && (hold_cnt == CNT_W'(HOLD_MAX));
  assign {s1, s0} = sel;
  assign busy = |gnt;
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    owner_n = owner;
    sel_n = sel;
    gnt_n = gnt;
    hold_cnt_n = hold_cnt;
    timeout_n = 1'b0;
    if (state == IDLE) begin
      if (|req) begin
        state_n = GRANT;
        owner_n = win;
        sel_n = win;
        gnt_n = 4'b0001 << win;
        hold_cnt_n = CNT_W'(1);
      end
    end else if (release_now || expire) begin
      // release wins a tie with expiry, so no timeout pulse then
      state_n = IDLE;
      gnt_n = '0;
      ptr_n = owner + 2'd1;
      timeout_n = !release_now;
    end else begin
      hold_cnt_n = hold_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      sel <= '0;
      gnt <= '0;
      hold_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      owner <= owner_n;
      sel <= sel_n;
      gnt <= gnt_n;
      hold_cnt <= hold_cnt_n;
      timeout <= timeout_n;
    end
  end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed and randomized checks of the round-robin mux arbiter
module tb_mux4_rr_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req_a = '0, req_b = '0;
  logic [3:0] gnt_a, gnt_b;
  logic s0_a, s1_a, busy_a, to_a, s0_b, s1_b, busy_b, to_b;
  int checks = 0, errors = 0;
  int m_own, m_cnt, m_ptr, m_sel, m_to;
  localparam int HM_A = 4;
  always #5 clk = ~clk;
  mux4_rr_arbiter #(.HOLD_MAX(HM_A), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .s0(s0_a), .s1(s1_a), .busy(busy_a), .timeout(to_a));
  mux4_rr_arbiter #(.HOLD_MAX(3), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .s0(s0_b), .s1(s1_b), .busy(busy_b), .timeout(to_b));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model_reset();
    m_own = -1; m_cnt = 0; m_ptr = 0; m_sel = 0; m_to = 0;
  endtask
  task automatic model_step(input logic [3:0] r);
    m_to = 0;
    if (m_own < 0) begin
      for (int k = 0; k < 4; k++)
        if (m_own < 0 && r[(m_ptr + k) % 4]) begin
          m_own = (m_ptr + k) % 4; m_cnt = 1; m_sel = m_own;
        end
    end else if (!r[m_own]) begin
      m_ptr = (m_own + 1) % 4; m_own = -1;
    end else if (HM_A != 0 && m_cnt == HM_A) begin
      m_to = 1; m_ptr = (m_own + 1) % 4; m_own = -1;
    end else m_cnt++;
  endtask
  task automatic test_reset();
    rst = 1'b1; req_a = 4'b1111;
    tick(); tick();
    checks++; if (gnt_a !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt_a); end
    checks++; if ({s1_a, s0_a} !== 2'b00) begin errors++; $display("FAIL reset_sel: got %b want 00", {s1_a, s0_a}); end
    checks++; if ({busy_a, to_a} !== 2'b00) begin errors++; $display("FAIL reset_busy_to: got %b want 00", {busy_a, to_a}); end
    rst = 1'b0;
    tick();
    checks++; if (gnt_a !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b want 0001", gnt_a); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL reset_first_busy: got %b want 1", busy_a); end
    req_a = 4'b0000;
    tick();
    checks++; if (gnt_a !== 4'b0000) begin errors++; $display("FAIL reset_release: got %b want 0000", gnt_a); end
  endtask
  task automatic test_single();
    req_a = 4'b0100;
    tick();
    checks++; if (gnt_a !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b want 0100", gnt_a); end
    checks++; if ({s1_a, s0_a} !== 2'b10) begin errors++; $display("FAIL single_sel: got %b want 10", {s1_a, s0_a}); end
    tick(); tick();
    checks++; if (gnt_a !== 4'b0100) begin errors++; $display("FAIL single_hold: got %b want 0100", gnt_a); end
    req_a = 4'b0000;
    tick();
    checks++; if ({gnt_a, busy_a, to_a} !== 6'b0000_00) begin errors++; $display("FAIL single_drop: got %b want 000000", {gnt_a, busy_a, to_a}); end
    checks++; if ({s1_a, s0_a} !== 2'b10) begin errors++; $display("FAIL single_sel_keep: got %b want 10", {s1_a, s0_a}); end
  endtask
  task automatic test_wrap();
    req_a = 4'b0011;
    tick();
    checks++; if (gnt_a !== 4'b0001) begin errors++; $display("FAIL wrap_gnt: got %b want 0001", gnt_a); end
    req_a = 4'b0000;
    tick();
  endtask
  task automatic test_rotation();
    logic [3:0] want;
    rst = 1'b1; tick(); rst = 1'b0;
    req_a = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      want = 4'b0001 << (n % 4);
      for (int c = 0; c < HM_A; c++) begin
        tick();
        checks++; if ({gnt_a, to_a} !== {want, 1'b0}) begin errors++; $display("FAIL rot_grant n%0d c%0d: got %b want %b", n, c, {gnt_a, to_a}, {want, 1'b0}); end
        checks++; if ({s1_a, s0_a} !== 2'(n % 4)) begin errors++; $display("FAIL rot_sel n%0d: got %b want %0d", n, {s1_a, s0_a}, n % 4); end
      end
      tick();
      checks++; if ({gnt_a, to_a} !== 5'b0000_1) begin errors++; $display("FAIL rot_gap n%0d: got %b want 00001", n, {gnt_a, to_a}); end
    end
    req_a = 4'b0000;
    tick();
  endtask
  task automatic test_tie();
    req_b = 4'b0010;
    tick(); tick(); tick();
    checks++; if (gnt_b !== 4'b0010) begin errors++; $display("FAIL tie_hold: got %b want 0010", gnt_b); end
    req_b = 4'b0000;
    tick();
    checks++; if ({gnt_b, to_b} !== 5'b0000_0) begin errors++; $display("FAIL tie_release: got %b want 00000", {gnt_b, to_b}); end
    req_b = 4'b1000;
    tick(); tick(); tick();
    tick();
    checks++; if ({gnt_b, to_b} !== 5'b0000_1) begin errors++; $display("FAIL tie_timeout: got %b want 00001", {gnt_b, to_b}); end
    tick();
    checks++; if ({gnt_b, to_b} !== 5'b1000_0) begin errors++; $display("FAIL tie_regrant: got %b want 10000", {gnt_b, to_b}); end
    req_b = 4'b0000;
    tick();
  endtask
  task automatic test_async_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    req_a = 4'b0010;
    tick(); tick();
    checks++; if (gnt_a !== 4'b0010) begin errors++; $display("FAIL async_pre: got %b want 0010", gnt_a); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({gnt_a, busy_a} !== 5'b0000_0) begin errors++; $display("FAIL async_drop: got %b want 00000", {gnt_a, busy_a}); end
    tick();
    rst = 1'b0; req_a = 4'b1111;
    tick();
    checks++; if (gnt_a !== 4'b0001) begin errors++; $display("FAIL async_restart: got %b want 0001", gnt_a); end
    req_a = 4'b0000;
    tick();
  endtask
  task automatic test_random();
    logic [3:0] r, eg;
    rst = 1'b1; tick(); rst = 1'b0;
    model_reset();
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      req_a = r;
      model_step(r);
      tick();
      eg = (m_own < 0) ? 4'b0000 : 4'b0001 << m_own;
      checks++; if ({gnt_a, s1_a, s0_a, busy_a, to_a} !== {eg, 2'(m_sel), m_own >= 0, m_to[0]})
        begin errors++; $display("FAIL random cyc%0d: got %b want %b", i, {gnt_a, s1_a, s0_a, busy_a, to_a}, {eg, 2'(m_sel), m_own >= 0, m_to[0]}); end
    end
    req_a = 4'b0000;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_rotation();
    test_tie();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
